// File: rtl/game_timer.sv
// game_timer: game-time base for the game-state FSM.
// Provides a saturating minute count, a one-cycle minute strobe and a
// quiz-deadline comparator. Time only advances in RUN while `run` is high.
// Optional build macro GAME_TIMER_BCD_EN adds a three-digit BCD copy of
// `minutes` (minutes_bcd), registered one cycle behind `minutes`.
module game_timer #(
    parameter int TICKS_PER_MIN = 50000000,
    parameter int MAX_MIN       = 255,
    parameter int PRE_W         = 26
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       run,
    input  logic       clear,
    input  logic       arm,
    input  logic [3:0] arm_len,
    input  logic       disarm,
    output logic [7:0] minutes,
    output logic       min_tick,
    output logic       deadline_hit,
    output logic       running,
    output logic [1:0] state_dbg
`ifdef GAME_TIMER_BCD_EN
    ,
    output logic [11:0] minutes_bcd
`endif
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_SAT     = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MIN - 1);
    localparam logic [7:0]       MAX_M    = 8'(MAX_MIN);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       min_d;
    logic             inc;
    logic             inc_pend;
    logic             armed;
    logic [7:0]       target;
    logic [8:0]       tgt_sum;
    logic [7:0]       tgt_new;

    assign state_dbg = state_q;

    // State register plus prescaler and minute count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_STOPPED;
            pre_q   <= '0;
            minutes <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            minutes <= min_d;
        end
    end

    // Next state, prescaler and minute arithmetic; clear beats everything.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        min_d   = minutes;
        inc     = 1'b0;
        running = (state_q == ST_RUN);
        if (clear) begin
            state_d = ST_STOPPED;
            pre_d   = '0;
            min_d   = '0;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    pre_d = '0;
                    min_d = '0;
                    if (Start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (run) begin
                        if (pre_q == PRE_LAST) begin
                            pre_d = '0;
                            inc   = 1'b1;
                            if (({1'b0, minutes} + 9'd1) >= {1'b0, MAX_M}) begin
                                min_d   = MAX_M;
                                state_d = ST_SAT;
                            end else begin
                                min_d = minutes + 8'd1;
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                end
                ST_SAT: begin
                    state_d = ST_SAT;
                end
                default: begin
                    state_d = ST_STOPPED;
                end
            endcase
        end
    end

    // Minute strobe: shows up one cycle after the minutes register changes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inc_pend <= 1'b0;
            min_tick <= 1'b0;
        end else if (clear) begin
            inc_pend <= 1'b0;
            min_tick <= 1'b0;
        end else begin
            inc_pend <= inc;
            min_tick <= inc_pend;
        end
    end

    // Deadline target is built from the pre-increment minutes, then saturated.
    assign tgt_sum = {1'b0, minutes} + {5'd0, arm_len};
    assign tgt_new = (tgt_sum > {1'b0, MAX_M}) ? MAX_M : tgt_sum[7:0];

    // Deadline arming and registered comparison; arm beats disarm.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            armed        <= 1'b0;
            target       <= '0;
            deadline_hit <= 1'b0;
        end else if (clear) begin
            armed        <= 1'b0;
            target       <= '0;
            deadline_hit <= 1'b0;
        end else begin
            if (arm) begin
                armed  <= 1'b1;
                target <= tgt_new;
            end else if (disarm) begin
                armed <= 1'b0;
            end
            deadline_hit <= armed & (minutes >= target);
        end
    end

`ifdef GAME_TIMER_BCD_EN
    localparam logic [11:0] MAX_BCD = {4'((MAX_MIN / 100) % 10),
                                       4'((MAX_MIN / 10) % 10),
                                       4'(MAX_MIN % 10)};
    logic [11:0] bcd_d;

    // Decimal increment with carries across ones, tens and hundreds.
    always_comb begin
        bcd_d = minutes_bcd;
        if (minutes_bcd[3:0] == 4'd9) begin
            bcd_d[3:0] = 4'd0;
            if (minutes_bcd[7:4] == 4'd9) begin
                bcd_d[7:4]  = 4'd0;
                bcd_d[11:8] = minutes_bcd[11:8] + 4'd1;
            end else begin
                bcd_d[7:4] = minutes_bcd[7:4] + 4'd1;
            end
        end else begin
            bcd_d[3:0] = minutes_bcd[3:0] + 4'd1;
        end
    end

    // BCD counter follows each minute increment one cycle later.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            minutes_bcd <= '0;
        end else if (clear) begin
            minutes_bcd <= '0;
        end else if (inc_pend && (minutes_bcd != MAX_BCD)) begin
            minutes_bcd <= bcd_d;
        end
    end
`endif

endmodule
